instr_fetch_sequencer: RTL and testbench
========================================

Name: instr_fetch_sequencer

Overview:
Fetch-side controller that sits directly upstream of the 16-bit instruction register. It owns the program counter and presents byte addresses to instruction memory. It drives the register's Write/LH strobes to assemble each 16-bit instruction from two consecutive bytes, then holds the instruction valid until the decode/control stage acknowledges it.

Parameters:
ADDR_W, 8, width of program counter and memory address
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of the retired-fetch counter

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Enable  input  1  run permission; low freezes fetch progress
Ack  input  1  decode stage has consumed the held instruction
Branch  input  1  redirect request, qualified by Ack in HOLD
BranchAddr  input  ADDR_W  redirect target
MemAddr  output  ADDR_W  instruction memory byte address (= PC)
MemRead  output  1  memory read strobe
IRWrite  output  1  instruction register write enable
IRLH  output  1  instruction register half select (1 = bits 15:8)
InstrValid  output  1  IR holds a complete instruction
PC  output  ADDR_W  current program counter
FetchCount  output  CNT_W  number of completed 16-bit fetches

Behaviour:
- The memory read is combinational. Byte data for MemAddr reaches the IR data input in the same cycle. The IR captures it on the next rising edge when IRWrite=1.
- States: IDLE, FETCH_L, FETCH_H, HOLD. The state, PC and FetchCount are registered. MemAddr, MemRead, IRWrite, IRLH and InstrValid decode combinationally from state and Enable.
- Reset (async, any time, including mid-fetch):
  - state=IDLE, PC=RESET_PC, FetchCount=0.
  - Outputs: MemRead=0, IRWrite=0, IRLH=0, InstrValid=0.
  - IR contents are not touched by this block.
- IDLE:
  - All strobes are 0.
  - Enable=1 -> FETCH_L at the next edge. PC is unchanged.
- FETCH_L:
  - MemAddr=PC, MemRead=Enable, IRWrite=Enable, IRLH=0.
  - With Enable=1 at the edge: PC<=PC+1, state FETCH_H.
  - With Enable=0: state and PC hold, strobes are 0.
- FETCH_H:
  - MemAddr=PC, MemRead=Enable, IRWrite=Enable, IRLH=1.
  - With Enable=1 at the edge: PC<=PC+1, FetchCount<=FetchCount+1, state HOLD.
  - With Enable=0: hold.
- Byte order is little-endian. The byte at the even-position address goes to IR[7:0], and the next byte goes to IR[15:8].
- HOLD:
  - InstrValid=1, IRWrite=0, MemRead=0. Enable is ignored.
  - Ack=0: stay in HOLD.
  - Ack=1 at the edge: state FETCH_L. If Branch=1 in the same cycle, PC<=BranchAddr; otherwise PC is unchanged.
- Branch is ignored in every state other than HOLD, and in HOLD when Ack=0.
- Latency: from the first Enable edge out of IDLE, InstrValid rises 3 cycles later (IDLE->FETCH_L->FETCH_H->HOLD). Back-to-back throughput is one instruction per 3 cycles with Ack held high.
- Arithmetic:
  - PC increments modulo 2^ADDR_W, so 0xFF+1 -> 0x00 with no flag. A fetch whose low byte sits at 0xFF reads its high byte from 0x00.
  - FetchCount wraps modulo 2^CNT_W silently.
- Enable dropping between FETCH_L and FETCH_H leaves the IR with only its low half updated. Fetch resumes at FETCH_H at the same PC, and InstrValid stays 0 until completion.

Test Plan:
- Reset release with mem[0]=0x34, mem[1]=0x12, Enable=1, Ack=0 -> IRWrite/IRLH go 1/0 then 1/1 at MemAddr 0x00 then 0x01. The IR reads 0x1234, InstrValid=1 on the third cycle, PC=0x02, FetchCount=1.
- In HOLD, pulse Ack=1 with Branch=1, BranchAddr=0x40, mem[0x40]=0xCD, mem[0x41]=0xAB -> the next fetch reads 0x40/0x41, IR=0xABCD, PC=0x42.
- In HOLD, hold Ack=0 for 5 cycles while toggling Enable and Branch -> state, PC and IR are unchanged, InstrValid stays 1, and there are no IRWrite pulses.
- Enable=0 for 2 cycles while in FETCH_H -> IRWrite=0 during the stall. The fetch then completes at the same PC with a correct 16-bit IR value.
- Branch to 0xFF with mem[0xFF]=0x78, mem[0x00]=0x56 -> IR=0x5678, PC wraps to 0x01.
- Assert Reset asynchronously mid-FETCH_H -> all outputs zero immediately without waiting for a clock edge. PC=RESET_PC, FetchCount=0, state IDLE.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_sequencer                                                    |
// | Owns the PC, assembles 16-bit instructions from two byte reads into the  |
// | downstream IR, and holds them valid until the decode stage acknowledges. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Ack,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] BranchAddr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              IRWrite,
  output logic              IRLH,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] PC,
  output logic [CNT_W-1:0]  FetchCount
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH_L = 2'd1,
    S_FETCH_H = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_fetch_count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Enable) r_state <= S_FETCH_L;
        end
        S_FETCH_L: begin
          if (Enable) begin
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_FETCH_H;
          end
        end
        S_FETCH_H: begin
          if (Enable) begin
            r_pc          <= r_pc + ADDR_W'(1);
            r_fetch_count <= r_fetch_count + CNT_W'(1);
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Branch only takes effect together with the acknowledge.
          if (Ack) begin
            r_state <= S_FETCH_L;
            if (Branch) r_pc <= BranchAddr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state so an async reset clears them immediately.
  always_comb begin
    MemRead    = 1'b0;
    IRWrite    = 1'b0;
    IRLH       = 1'b0;
    InstrValid = 1'b0;
    case (r_state)
      S_FETCH_L: begin
        MemRead = Enable;
        IRWrite = Enable;
      end
      S_FETCH_H: begin
        MemRead = Enable;
        IRWrite = Enable;
        IRLH    = 1'b1;
      end
      S_HOLD:  InstrValid = 1'b1;
      default: ;
    endcase
  end

  assign MemAddr    = r_pc;
  assign PC         = r_pc;
  assign FetchCount = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch_sequencer                                                 |
// | Self-checking bench with byte memory, IR model and expected-fetch queue. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable;
  logic        Ack;
  logic        Branch;
  logic [7:0]  BranchAddr;
  logic [7:0]  MemAddr;
  logic        MemRead;
  logic        IRWrite;
  logic        IRLH;
  logic        InstrValid;
  logic [7:0]  PC;
  logic [15:0] FetchCount;

  logic [7:0]  mem [0:255];
  logic [15:0] ir_model = 16'h0000;
  logic        prev_valid = 1'b0;

  typedef struct {
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  instr_fetch_sequencer #(
    .ADDR_W  (8),
    .RESET_PC(8'h00),
    .CNT_W   (16)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enable    (Enable),
    .Ack       (Ack),
    .Branch    (Branch),
    .BranchAddr(BranchAddr),
    .MemAddr   (MemAddr),
    .MemRead   (MemRead),
    .IRWrite   (IRWrite),
    .IRLH      (IRLH),
    .InstrValid(InstrValid),
    .PC        (PC),
    .FetchCount(FetchCount)
  );

  always #5 Clock = ~Clock;

  // Instruction register sitting downstream of the sequencer.
  always @(posedge Clock) begin
    if (IRWrite) begin
      if (IRLH) ir_model[15:8] <= mem[MemAddr];
      else      ir_model[7:0]  <= mem[MemAddr];
    end
  end

  // Scoreboard drain: each new valid instruction is matched against the queue.
  always @(negedge Clock) begin
    if (InstrValid && !prev_valid) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: instruction %h appeared with nothing expected", ir_model);
      end else begin
        e = exp_q.pop_front();
        if (ir_model !== e.ir || PC !== e.pc || FetchCount !== e.cnt) begin
          errors++;
          $display("FAIL sb_fetch: got ir=%h pc=%h cnt=%0d, expected ir=%h pc=%h cnt=%0d",
                   ir_model, PC, FetchCount, e.ir, e.pc, e.cnt);
        end
      end
    end
    prev_valid <= InstrValid;
  end

  task automatic wait_valid(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (InstrValid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout: InstrValid=%b after %0d cycles, expected 1", InstrValid, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge Clock);
    @(negedge Clock);
    checks++;
    if ({MemRead, IRWrite, IRLH, InstrValid} !== 4'b0000 || PC !== 8'h00 || FetchCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: strobes=%b pc=%h cnt=%0d, expected 0000/00/0",
               {MemRead, IRWrite, IRLH, InstrValid}, PC, FetchCount);
    end
  endtask

  task automatic test_first_fetch();
    mem[8'h00] = 8'h34;
    mem[8'h01] = 8'h12;
    exp_q.push_back('{16'h1234, 8'h02, 16'd1});
    Reset = 1'b0; Enable = 1'b1; Ack = 1'b0;
    #1;
    checks++;
    if (IRWrite !== 1'b0 || MemRead !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobes: IRWrite=%b MemRead=%b, expected 0/0", IRWrite, MemRead);
    end
    @(negedge Clock);
    checks++;
    if ({IRWrite, IRLH, MemRead} !== 3'b101 || MemAddr !== 8'h00) begin
      errors++;
      $display("FAIL fetch_low: IRWrite/IRLH/MemRead=%b addr=%h, expected 101/00",
               {IRWrite, IRLH, MemRead}, MemAddr);
    end
    @(negedge Clock);
    checks++;
    if ({IRWrite, IRLH, MemRead} !== 3'b111 || MemAddr !== 8'h01) begin
      errors++;
      $display("FAIL fetch_high: IRWrite/IRLH/MemRead=%b addr=%h, expected 111/01",
               {IRWrite, IRLH, MemRead}, MemAddr);
    end
    @(negedge Clock);
    checks++;
    if (InstrValid !== 1'b1 || IRWrite !== 1'b0) begin
      errors++;
      $display("FAIL latency: InstrValid=%b IRWrite=%b on third cycle, expected 1/0", InstrValid, IRWrite);
    end
  endtask

  task automatic test_branch();
    mem[8'h40] = 8'hCD;
    mem[8'h41] = 8'hAB;
    exp_q.push_back('{16'hABCD, 8'h42, 16'd2});
    Ack = 1'b1; Branch = 1'b1; BranchAddr = 8'h40;
    @(negedge Clock);
    Ack = 1'b0; Branch = 1'b0;
    checks++;
    if (MemAddr !== 8'h40 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL branch_target: addr=%h valid=%b, expected 40/0", MemAddr, InstrValid);
    end
    wait_valid(6);
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      Enable = i[0]; Branch = ~i[0]; BranchAddr = 8'h10;
      #1;
      checks++;
      if (IRWrite !== 1'b0 || MemRead !== 1'b0) begin
        errors++;
        $display("FAIL hold_strobes: IRWrite=%b MemRead=%b at step %0d, expected 0/0", IRWrite, MemRead, i);
      end
      @(negedge Clock);
      checks++;
      if (InstrValid !== 1'b1 || PC !== 8'h42 || ir_model !== 16'hABCD) begin
        errors++;
        $display("FAIL hold_state: valid=%b pc=%h ir=%h at step %0d, expected 1/42/abcd",
                 InstrValid, PC, ir_model, i);
      end
    end
    Enable = 1'b1; Branch = 1'b0;
  endtask

  task automatic test_enable_stall();
    mem[8'h42] = 8'h11;
    mem[8'h43] = 8'h22;
    exp_q.push_back('{16'h2211, 8'h44, 16'd3});
    Ack = 1'b1;
    @(negedge Clock);
    Ack = 1'b0;
    checks++;
    if (MemAddr !== 8'h42 || IRWrite !== 1'b1 || IRLH !== 1'b0) begin
      errors++;
      $display("FAIL stall_fetch_low: addr=%h IRWrite=%b IRLH=%b, expected 42/1/0", MemAddr, IRWrite, IRLH);
    end
    @(negedge Clock);
    Enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (IRWrite !== 1'b0 || MemRead !== 1'b0 || MemAddr !== 8'h43 || InstrValid !== 1'b0 ||
          ir_model[7:0] !== 8'h11) begin
        errors++;
        $display("FAIL stall_hold: IRWrite=%b MemRead=%b addr=%h valid=%b irlo=%h, expected 0/0/43/0/11",
                 IRWrite, MemRead, MemAddr, InstrValid, ir_model[7:0]);
      end
      @(negedge Clock);
    end
    Enable = 1'b1;
    #1;
    checks++;
    if (IRWrite !== 1'b1 || IRLH !== 1'b1 || MemAddr !== 8'h43) begin
      errors++;
      $display("FAIL stall_resume: IRWrite=%b IRLH=%b addr=%h, expected 1/1/43", IRWrite, IRLH, MemAddr);
    end
    wait_valid(4);
  endtask

  task automatic test_wrap();
    mem[8'hFF] = 8'h78;
    mem[8'h00] = 8'h56;
    exp_q.push_back('{16'h5678, 8'h01, 16'd4});
    Ack = 1'b1; Branch = 1'b1; BranchAddr = 8'hFF;
    @(negedge Clock);
    Ack = 1'b0; Branch = 1'b0;
    @(negedge Clock);
    checks++;
    if (MemAddr !== 8'h00 || IRLH !== 1'b1) begin
      errors++;
      $display("FAIL wrap_addr: addr=%h IRLH=%b, expected 00/1", MemAddr, IRLH);
    end
    wait_valid(4);
  endtask

  task automatic test_back_to_back();
    mem[8'h01] = 8'h21;
    mem[8'h02] = 8'h43;
    mem[8'h03] = 8'h65;
    mem[8'h04] = 8'h87;
    exp_q.push_back('{16'h4321, 8'h03, 16'd5});
    exp_q.push_back('{16'h8765, 8'h05, 16'd6});
    Ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      checks++;
      if (InstrValid !== ((k % 3) == 2)) begin
        errors++;
        $display("FAIL back_to_back: valid=%b at cycle %0d, expected %b", InstrValid, k, (k % 3) == 2);
      end
    end
    Ack = 1'b0;
  endtask

  task automatic test_async_reset();
    Ack = 1'b1;
    @(negedge Clock);
    Ack = 1'b0;
    @(negedge Clock);
    checks++;
    if (IRWrite !== 1'b1 || IRLH !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: IRWrite=%b IRLH=%b, expected 1/1", IRWrite, IRLH);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({MemRead, IRWrite, IRLH, InstrValid} !== 4'b0000 || PC !== 8'h00 ||
        MemAddr !== 8'h00 || FetchCount !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: strobes=%b pc=%h addr=%h cnt=%0d, expected 0000/00/00/0",
               {MemRead, IRWrite, IRLH, InstrValid}, PC, MemAddr, FetchCount);
    end
    @(negedge Clock);
    Reset = 1'b0; Enable = 1'b0;
    @(negedge Clock);
    checks++;
    if (IRWrite !== 1'b0 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: IRWrite=%b valid=%b, expected 0/0", IRWrite, InstrValid);
    end
    Enable = 1'b1;
    @(negedge Clock);
    checks++;
    if (MemAddr !== 8'h00 || IRWrite !== 1'b1 || IRLH !== 1'b0) begin
      errors++;
      $display("FAIL restart: addr=%h IRWrite=%b IRLH=%b, expected 00/1/0", MemAddr, IRWrite, IRLH);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    Reset = 1'b1; Enable = 1'b0; Ack = 1'b0; Branch = 1'b0; BranchAddr = 8'h00;
    test_reset();
    test_first_fetch();
    test_branch();
    test_hold_stall();
    test_enable_stall();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected fetches never observed, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
